// File: rtl/address_strobe_sequencer_pkg.sv
// Shared types and sizing helpers for the address strobe sequencer.
package addr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int unsigned ADDR_BITS_DEF = 4;

  // Phase counter width: clog2 of the longest phase, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/address_strobe_sequencer_if.sv
// Request handshake and decode-tree outputs of the address strobe sequencer.
// ReqCount exists only when ADDR_SEQ_BURST_EN is defined.
interface address_strobe_sequencer_if
  import addr_seq_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
);
  logic                 ReqValid;
  logic                 ReqReady;
  logic [ADDR_BITS-1:0] ReqAddress;
`ifdef ADDR_SEQ_BURST_EN
  logic [3:0]           ReqCount;
`endif
  logic [ADDR_BITS-1:0] ToDecode;
  logic                 Enable;
  logic                 Busy;
  logic                 Done;

  modport master (
    output ReqValid, ReqAddress,
`ifdef ADDR_SEQ_BURST_EN
    output ReqCount,
`endif
    input  ReqReady, ToDecode, Enable, Busy, Done
  );

  modport slave (
    input  ReqValid, ReqAddress,
`ifdef ADDR_SEQ_BURST_EN
    input  ReqCount,
`endif
    output ReqReady, ToDecode, Enable, Busy, Done
  );
endinterface

// File: rtl/address_strobe_sequencer_phase_counter.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// Zero is taken from the current count, so the caller decides before any decrement.
module phase_counter #(
  parameter int unsigned CW = 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Load,
  input  logic [CW-1:0] LoadValue,
  input  logic          Dec,
  output logic          Zero
);
  logic [CW-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (Load)
      cnt_d = LoadValue;
    else if (Dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign Zero = (cnt_q == '0);
endmodule

// File: rtl/address_strobe_sequencer.sv
// Address strobe sequencer: accepts an address and presents it to the decode
// tree with a setup / strobe / hold envelope, Enable high only while settled.
// Optional feature macro: ADDR_SEQ_BURST_EN (multi-access bursts via ReqCount).
module address_strobe_sequencer
  import addr_seq_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  address_strobe_sequencer_if.slave   bus
);
  localparam int unsigned   CW        = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cnt_load;
  logic [CW-1:0]        cnt_load_val;
  logic                 cnt_dec;
  logic                 cnt_zero;
`ifdef ADDR_SEQ_BURST_EN
  logic [3:0]           burst_q, burst_d;
`endif

  phase_counter #(.CW(CW)) u_phase_counter (
    .Clock     (Clock),
    .Reset     (Reset),
    .Load      (cnt_load),
    .LoadValue (cnt_load_val),
    .Dec       (cnt_dec),
    .Zero      (cnt_zero)
  );

  // Next-state, address and registered-output logic for the envelope FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
`ifdef ADDR_SEQ_BURST_EN
    burst_d      = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          addr_d       = bus.ReqAddress;
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LD;
          state_d      = SETUP;
`ifdef ADDR_SEQ_BURST_EN
          burst_d      = bus.ReqCount;
`endif
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = STROBE_LD;
          state_d      = STROBE;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
`ifdef ADDR_SEQ_BURST_EN
          if (burst_q != '0) begin
            burst_d      = burst_q - 4'd1;
            addr_d       = addr_q + 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = SETUP_LD;
            state_d      = SETUP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs follow the state being entered so they are registered yet aligned.
    enable_d = (state_d == STROBE);
    busy_d   = (state_d != IDLE);
    cnt_dec  = !cnt_load && (state_q != IDLE);
  end

  // FSM and output registers; reset forces every value, including a pending Done.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADDR_SEQ_BURST_EN
      burst_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ADDR_SEQ_BURST_EN
      burst_q  <= burst_d;
`endif
    end
  end

  assign bus.ReqReady = (state_q == IDLE);
  assign bus.ToDecode = addr_q;
  assign bus.Enable   = enable_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
endmodule
